// File: rtl/dsp_result_capture.sv
// Captures DSP48A1 P/CARRYOUT a fixed number of PCE-enabled edges after each issue and queues it in a show-ahead FIFO.
// Optional build macro: DSP_CAPTURE_DROPCNT_EN enables the saturating drop counter on DROP_CNT.
module dsp_result_capture #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PW      = 48
) (
  input  logic                     PCLK,
  input  logic                     PRST,
  input  logic                     PCE,
  input  logic                     ISSUE,
  input  logic [7:0]               OPMODE_TAG,
  input  logic [PW-1:0]            P,
  input  logic                     CARRYOUT,
  output logic                     DOUT_VALID,
  input  logic                     DOUT_READY,
  output logic [PW-1:0]            DOUT_P,
  output logic                     DOUT_CARRY,
  output logic [7:0]               DOUT_TAG,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic [15:0]              DROP_CNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PW + 9;

  logic [LATENCY-1:0] pipe_vld;
  logic [7:0]         pipe_tag [LATENCY];
  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic               ovf;
  logic [EW-1:0]      head;

  logic capture_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  assign capture_c = PCE & pipe_vld[LATENCY-1];
  assign full_c    = (count == CW'(DEPTH));
  assign pop_c     = (count != '0) & DOUT_READY;
  assign push_c    = capture_c & (~full_c | pop_c);
  assign drop_c    = capture_c & full_c & ~pop_c;

  // Tracking pipe: shifts only on PCE-enabled edges, mirroring the DSP pipeline.
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
    end else if (PCE) begin
      pipe_vld[0] <= ISSUE;
      pipe_tag[0] <= OPMODE_TAG;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Result FIFO storage and pointers; pointers wrap naturally at DEPTH.
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= {pipe_tag[LATENCY-1], CARRYOUT, P};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy and sticky overflow.
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop_c) ovf <= 1'b1;
    end
  end

`ifdef DSP_CAPTURE_DROPCNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      drop_cnt <= '0;
    end else if (drop_c && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign DROP_CNT = drop_cnt;
`else
  assign DROP_CNT = 16'h0000;
`endif

  // Head decode: zeros whenever the FIFO is empty.
  assign head       = mem[rd_ptr];
  assign DOUT_VALID = (count != '0);
  assign DOUT_P     = DOUT_VALID ? head[PW-1:0] : '0;
  assign DOUT_CARRY = DOUT_VALID ? head[PW] : 1'b0;
  assign DOUT_TAG   = DOUT_VALID ? head[EW-1:PW+1] : 8'h00;
  assign COUNT      = count;
  assign OVERFLOW   = ovf;

endmodule

// File: tb/tb_dsp_result_capture.sv
// Self-checking bench for dsp_result_capture: directed vector table, corner-case sequences and a random run vs a queue model.
module tb_dsp_result_capture;

  localparam int unsigned LATENCY = 4;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned PW      = 48;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic          PCLK = 1'b0;
  logic          PRST = 1'b1;
  logic          PCE = 1'b0;
  logic          ISSUE = 1'b0;
  logic [7:0]    OPMODE_TAG = '0;
  logic [PW-1:0] P = '0;
  logic          CARRYOUT = 1'b0;
  logic          DOUT_VALID;
  logic          DOUT_READY = 1'b0;
  logic [PW-1:0] DOUT_P;
  logic          DOUT_CARRY;
  logic [7:0]    DOUT_TAG;
  logic [CW-1:0] COUNT;
  logic          OVERFLOW;
  logic [15:0]   DROP_CNT;

  dsp_result_capture #(.LATENCY(LATENCY), .DEPTH(DEPTH), .PW(PW)) dut (
    .PCLK(PCLK), .PRST(PRST), .PCE(PCE), .ISSUE(ISSUE), .OPMODE_TAG(OPMODE_TAG),
    .P(P), .CARRYOUT(CARRYOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .DOUT_P(DOUT_P), .DOUT_CARRY(DOUT_CARRY), .DOUT_TAG(DOUT_TAG), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .DROP_CNT(DROP_CNT)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight ops carry the count of enabled edges seen since issue.
  typedef struct { logic [7:0] tag; int age; } fl_t;
  typedef struct { logic [PW-1:0] p; logic c; logic [7:0] tag; } ent_t;
  fl_t  inflight[$];
  ent_t fifo_q[$];
  bit   m_ovf = 0;
  int   m_drop = 0;

  function automatic int exp_drop();
`ifdef DSP_CAPTURE_DROPCNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    inflight.delete();
    fifo_q.delete();
    m_ovf = 0;
    m_drop = 0;
  endfunction

  function automatic void model_edge();
    bit   pop = (fifo_q.size() != 0) && DOUT_READY;
    bit   cap = 0;
    int   sz  = fifo_q.size();
    ent_t e;
    fl_t  f;
    if (PCE) begin
      if (inflight.size() != 0 && inflight[0].age == int'(LATENCY)) begin
        cap = 1;
        e = '{P, CARRYOUT, inflight[0].tag};
        void'(inflight.pop_front());
      end
      foreach (inflight[i]) inflight[i].age++;
      if (ISSUE) begin
        f = '{OPMODE_TAG, 1};
        inflight.push_back(f);
      end
    end
    if (pop) void'(fifo_q.pop_front());
    if (cap) begin
      if (sz < int'(DEPTH) || pop) fifo_q.push_back(e);
      else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
  endfunction

  task automatic step(input bit iss, input bit pce, input bit rdy, input logic [7:0] tag,
                      input logic [PW-1:0] p, input bit c);
    @(negedge PCLK);
    ISSUE = iss; PCE = pce; DOUT_READY = rdy; OPMODE_TAG = tag; P = p; CARRYOUT = c;
    model_edge();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_model(input string name);
    chk({name, ".valid"}, 64'(DOUT_VALID), 64'(fifo_q.size() != 0));
    chk({name, ".count"}, 64'(COUNT), 64'(fifo_q.size()));
    chk({name, ".ovf"}, 64'(OVERFLOW), 64'(m_ovf));
    chk({name, ".drop"}, 64'(DROP_CNT), 64'(exp_drop()));
    if (fifo_q.size() != 0) begin
      chk({name, ".p"}, 64'(DOUT_P), 64'(fifo_q[0].p));
      chk({name, ".carry"}, 64'(DOUT_CARRY), 64'(fifo_q[0].c));
      chk({name, ".tag"}, 64'(DOUT_TAG), 64'(fifo_q[0].tag));
    end else begin
      chk({name, ".p0"}, 64'(DOUT_P), 64'h0);
      chk({name, ".tag0"}, 64'(DOUT_TAG), 64'h0);
    end
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, ".valid"}, 64'(DOUT_VALID), 64'h0);
    chk({name, ".p"}, 64'(DOUT_P), 64'h0);
    chk({name, ".carry"}, 64'(DOUT_CARRY), 64'h0);
    chk({name, ".tag"}, 64'(DOUT_TAG), 64'h0);
    chk({name, ".count"}, 64'(COUNT), 64'h0);
    chk({name, ".ovf"}, 64'(OVERFLOW), 64'h0);
    chk({name, ".drop"}, 64'(DROP_CNT), 64'h0);
  endtask

  typedef struct {
    bit            iss, pce, rdy;
    logic [7:0]    tag;
    logic [PW-1:0] p;
    bit            ev;
    int            ec;
    logic [7:0]    et;
    logic [PW-1:0] ep;
  } vec_t;

  vec_t vt[15];
  int   cap_cnt;

  initial begin
    // Single op then a 3-cycle stall; expected outputs after each edge.
    vt[0]  = '{1, 1, 0, 8'h1D, 48'h0,              0, 0, 8'h00, 48'h0};
    vt[1]  = '{0, 1, 0, 8'h00, 48'h0,              0, 0, 8'h00, 48'h0};
    vt[2]  = '{0, 1, 0, 8'h00, 48'h0,              0, 0, 8'h00, 48'h0};
    vt[3]  = '{0, 1, 0, 8'h00, 48'h0,              0, 0, 8'h00, 48'h0};
    vt[4]  = '{0, 1, 0, 8'h00, 48'h0000_0000_ABCD, 1, 1, 8'h1D, 48'h0000_0000_ABCD};
    vt[5]  = '{0, 1, 1, 8'h00, 48'h0,              0, 0, 8'h00, 48'h0};
    vt[6]  = '{1, 1, 0, 8'h2E, 48'h0,              0, 0, 8'h00, 48'h0};
    vt[7]  = '{0, 0, 0, 8'h00, 48'hFFFF,           0, 0, 8'h00, 48'h0};
    vt[8]  = '{1, 0, 0, 8'h77, 48'hFFFF,           0, 0, 8'h00, 48'h0};
    vt[9]  = '{0, 0, 0, 8'h00, 48'hFFFF,           0, 0, 8'h00, 48'h0};
    vt[10] = '{0, 1, 0, 8'h00, 48'h0,              0, 0, 8'h00, 48'h0};
    vt[11] = '{0, 1, 0, 8'h00, 48'h0,              0, 0, 8'h00, 48'h0};
    vt[12] = '{0, 1, 0, 8'h00, 48'h0,              0, 0, 8'h00, 48'h0};
    vt[13] = '{0, 1, 0, 8'h00, 48'h1234_5678_9ABC, 1, 1, 8'h2E, 48'h1234_5678_9ABC};
    vt[14] = '{0, 1, 1, 8'h00, 48'h0,              0, 0, 8'h00, 48'h0};

    #12;
    check_reset_vals("reset");
    @(negedge PCLK);
    PRST = 1'b0;
    model_reset();

    for (int i = 0; i < 15; i++) begin
      step(vt[i].iss, vt[i].pce, vt[i].rdy, vt[i].tag, vt[i].p, 1'b0);
      chk($sformatf("vec%0d.valid", i), 64'(DOUT_VALID), 64'(vt[i].ev));
      chk($sformatf("vec%0d.count", i), 64'(COUNT), 64'(vt[i].ec));
      chk($sformatf("vec%0d.tag", i), 64'(DOUT_TAG), 64'(vt[i].et));
      chk($sformatf("vec%0d.p", i), 64'(DOUT_P), 64'(vt[i].ep));
    end

    // Back-to-back issue with the consumer always ready.
    for (int i = 0; i < 8 + int'(LATENCY) + 2; i++) begin
      step(i < 8, 1, 1, 8'(8'h40 + i), {16'(i), 32'($urandom)}, 1'(i));
      check_model("b2b");
      chk("b2b.count_le1", 64'(COUNT <= 1), 64'h1);
    end

    // Fill to full, drop two, then pop in the same cycle as a capture.
    for (int i = 0; i < 14; i++) begin
      step(i < 11, 1, 0, 8'(8'h80 + i), {16'hF000, 32'(i)}, 1'b1);
      check_model("full");
    end
    chk("full.count8", 64'(COUNT), 64'(DEPTH));
    chk("full.ovf", 64'(OVERFLOW), 64'h1);
`ifdef DSP_CAPTURE_DROPCNT_EN
    chk("full.drop2", 64'(DROP_CNT), 64'h2);
`else
    chk("full.drop0", 64'(DROP_CNT), 64'h0);
`endif
    step(0, 1, 1, 8'h00, 48'h0000_0000_BEEF, 1'b0);
    chk("full.pop_cap_count", 64'(COUNT), 64'(DEPTH));
    chk("full.pop_cap_head", 64'(DOUT_TAG), 64'h81);
    check_model("full_pop");
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 8'h00, 48'h0, 1'b0);
      check_model("drain");
    end
    chk("drain.ovf_sticky", 64'(OVERFLOW), 64'h1);

    // Reset mid-flight: two results queued, three ops in the pipe.
    for (int i = 0; i < 6; i++) begin
      step(i < 5, 1, 0, 8'(8'hC0 + i), 48'h5A5A, 1'b1);
    end
    chk("pre_rst.count", 64'(COUNT), 64'h2);
    PRST = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    #2;
    PRST = 1'b0;
    model_reset();
    cap_cnt = 0;
    for (int i = 0; i < int'(LATENCY) + 4; i++) begin
      step(0, 1, 0, 8'h00, 48'hDEAD, 1'b1);
      if (DOUT_VALID) cap_cnt++;
      check_model("post_rst");
    end
    chk("post_rst.no_stale", 64'(cap_cnt), 64'h0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 80),
           1'($urandom_range(0, 99) < ((i / 1000) % 2 == 0 ? 30 : 85)),
           8'($urandom), {16'($urandom), 32'($urandom)}, 1'($urandom));
      check_model("rand");
      chk("rand.count_le_depth", 64'(COUNT <= CW'(DEPTH)), 64'h1);
    end
    chk("rand.final_drop", 64'(DROP_CNT), 64'(exp_drop()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_result_capture.md
# dsp_result_capture

Result-side companion to the DSP48A1 slice. It tracks every operation launched into the DSP pipeline and captures the matching P/CARRYOUT value after the configured pipeline latency. It honours PCE stalls. Captured results go, tagged with the OPMODE that produced them, into a small show-ahead FIFO drained over a valid/ready handshake. It sits between the DSP48A1 outputs and whatever consumer (checker, packetiser, host readback) reads results.

## Interface
- LATENCY, 4: number of PCE-enabled edges from operand launch to P valid; legal 1..16.
- DEPTH, 8: FIFO entries; power of two, 2..64.
- PW, 48: width of P.
- PCLK in 1: clock, rising edge.
- PRST in 1: reset, asynchronous, active-high; clears all state.
- PCE in 1: DSP clock enable; the tracking pipeline advances only when high.
- ISSUE in 1: an operation is launched into the DSP on this edge; qualified by PCE.
- OPMODE_TAG in 8: OPMODE of the launched operation.
- P in PW: DSP48A1 P output.
- CARRYOUT in 1: DSP48A1 CARRYOUT output.
- DOUT_VALID out 1: FIFO head holds a result.
- DOUT_READY in 1: consumer accepts the head.
- DOUT_P out PW: head P.
- DOUT_CARRY out 1: head carry.
- DOUT_TAG out 8: head OPMODE tag.
- COUNT out clog2(DEPTH)+1: FIFO occupancy.
- OVERFLOW out 1: sticky; set when a capture is dropped.
- DROP_CNT out 16: saturating count of dropped captures.

## Operation
- Tracking pipe: LATENCY stages, each holding {valid, tag}.
  - On an edge with PCE=1: stage0 <= {ISSUE, OPMODE_TAG} and stage i <= stage i-1.
  - With PCE=0, the pipe holds and ISSUE is ignored.
- Capture: on an edge with PCE=1 and last-stage valid=1, {P, CARRYOUT, tag} is written to the FIFO.
  - P is sampled as presented before that edge.
  - With PCE=0, no capture occurs, even if the last stage is valid.
- FIFO: show-ahead.
  - DOUT_* always reflect the head entry; DOUT_P, DOUT_CARRY and DOUT_TAG are driven 0 when empty.
  - A pop happens on DOUT_VALID & DOUT_READY.
  - DOUT_READY while empty has no effect.
- Full boundary:
  - Capture while full with no pop in the same cycle: the capture is dropped, OVERFLOW is set, and DROP_CNT increments (saturating at 16'hFFFF).
  - Capture while full with a pop in the same cycle: the write is accepted and COUNT is unchanged.
- Empty boundary: a capture into an empty FIFO is visible (DOUT_VALID=1) on the next cycle; there is no bypass.
- Pointer wrap: read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- PRST asserted mid-operation: in-flight pipe entries and FIFO contents are discarded immediately. This matches the DSP clearing P on PRST.
- OVERFLOW clears only on PRST.

## Timing
- Reset values:
  - DOUT_VALID=0, DOUT_P=0, DOUT_CARRY=0, DOUT_TAG=0.
  - COUNT=0, OVERFLOW=0, DROP_CNT=0.
  - All pipe valids=0.
- With continuous PCE=1: ISSUE sampled at edge n is captured at edge n+LATENCY and appears on DOUT_VALID after edge n+LATENCY.
- Each PCE=0 cycle adds one cycle to that latency.
- Issue throughput: one per cycle.
- Drain throughput: one pop per cycle.
- COUNT updates on the same edge as the push/pop.
- All outputs are registered or decoded from registers; there is no combinational path from P, CARRYOUT or DOUT_READY to any output.

## Configuration
- DSP_CAPTURE_DROPCNT_EN defined: DROP_CNT counts dropped captures as described.
- Not defined:
  - The counter logic is omitted and DROP_CNT is tied to 16'h0000.
  - OVERFLOW behaviour is unchanged.
  - The port list is identical in both builds.

## Test plan
- Single op, LATENCY=4, PCE=1: ISSUE at edge 1 with tag 8'h1D, P=48'h0000_0000_ABCD on the capture edge -> DOUT_VALID=1 after edge 5, DOUT_P=48'h0000_0000_ABCD, DOUT_TAG=8'h1D.
- Stall: as above, with PCE=0 for 3 cycles after issue -> capture delayed by exactly 3 cycles; no capture on stalled edges.
- Back-to-back: 8 issues on consecutive cycles, DOUT_READY=1 -> 8 results in issue order, one per cycle, COUNT never exceeds 1.
- Full: DEPTH=8, DOUT_READY=0, 10 issues -> COUNT=8, OVERFLOW=1, DROP_CNT=2 (0 when DSP_CAPTURE_DROPCNT_EN is undefined). Then one pop coinciding with a capture -> COUNT stays 8.
- Reset mid-flight: 3 ops in the pipe plus 2 in the FIFO, PRST pulsed between edges -> all outputs return to reset values immediately and no stale capture appears afterwards.
- Random: 10000 cycles of random ISSUE/PCE/DOUT_READY/OPMODE_TAG against a behavioural model -> tag/P order matches, COUNT never exceeds DEPTH, DROP_CNT equals the model's drop count.
